mem_port_arbiter: RTL and testbench

Shares one single-ported, word-wide memory between the fetch stage's instruction port and the memory stage's data port of the pipelined RISC-V core. It grants one requester at a time, holds the winning transaction until the memory handshakes, and returns read data or a write acknowledgement to the owner. A starvation guard prevents a run of loads and stores from blocking fetch indefinitely. A flush input discards an in-flight fetch after a taken branch or jump.

---
 rtl/riscv_mem_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
`default_nettype none

package riscv_mem_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Arbiter FSM encodings
  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_BUSY_IF = 2'd1;
  localparam logic [1:0] ARB_BUSY_DM = 2'd2;

  // Requester IDs
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  function automatic logic [1:0] busy_state(input logic req_id);
    return (req_id == REQ_DM) ? ARB_BUSY_DM : ARB_BUSY_IF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side bus of the memory port arbiter.
`default_nettype none

interface mem_port_arbiter_if
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_flush;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;

  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic [3:0]      dm_be;
  logic            dm_gnt;
  logic            dm_rvalid;
  logic [XLEN-1:0] dm_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ready
  );

  // Core/memory side
  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one single-ported memory between fetch and data
//                    ports with a starvation guard and fetch flush
// Revision 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus,
  output logic               busy
);

  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic            w_if_gnt;
  logic            w_dm_gnt;
  logic            w_mem_req;
  logic [3:0]      r_streak;
  logic            r_drop;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [3:0]      r_mem_be;
  logic            r_if_rvalid;
  logic [XLEN-1:0] r_if_rdata;
  logic            r_dm_rvalid;
  logic [XLEN-1:0] r_dm_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_if_gnt) begin
          w_next_state = busy_state(REQ_IF);
        end else if (w_dm_gnt) begin
          w_next_state = busy_state(REQ_DM);
        end
      end
      ARB_BUSY_IF, ARB_BUSY_DM: begin
        if (bus.mem_ready) begin
          w_next_state = ARB_IDLE;
        end
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // Data wins ties unless fetch has already waited out the starvation limit.
  always_comb begin
    w_if_gnt  = 1'b0;
    w_dm_gnt  = 1'b0;
    w_mem_req = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_if_gnt = bus.if_req && (!bus.dm_req || (r_streak == C_STARVE_LIMIT));
        w_dm_gnt = bus.dm_req && !w_if_gnt;
      end
      ARB_BUSY_IF, ARB_BUSY_DM: w_mem_req = 1'b1;
      default: w_mem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= 4'd0;
    end else if (w_if_gnt) begin
      r_streak <= 4'd0;
    end else if (w_dm_gnt) begin
      if (!bus.if_req) begin
        r_streak <= 4'd0;
      end else if (r_streak != C_STARVE_LIMIT) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'd0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      if (w_if_gnt) begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.if_addr;
        r_mem_wdata <= '0;
        r_mem_be    <= 4'hF;
        r_drop      <= bus.if_flush;
      end else if (w_dm_gnt) begin
        r_mem_we    <= bus.dm_we;
        r_mem_addr  <= bus.dm_addr;
        r_mem_wdata <= bus.dm_wdata;
        r_mem_be    <= bus.dm_be;
      end
      // A flushed fetch still runs to completion; only its response is dropped.
      if (r_state == ARB_BUSY_IF) begin
        if (bus.mem_ready) begin
          r_drop <= 1'b0;
          if (!(r_drop || bus.if_flush)) begin
            r_if_rvalid <= 1'b1;
            r_if_rdata  <= bus.mem_rdata;
          end
        end else if (bus.if_flush) begin
          r_drop <= 1'b1;
        end
      end
      if ((r_state == ARB_BUSY_DM) && bus.mem_ready) begin
        r_dm_rvalid <= 1'b1;
        r_dm_rdata  <= r_mem_we ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.dm_rdata  = r_dm_rdata;
  assign busy          = w_mem_req;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a transaction-level model.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_vec = 0;
  int   n_bad = 0;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the single in-flight transaction, pending responses, starvation count.
  bit          t_valid = 0, t_is_if = 0, t_we = 0, t_drop = 0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  logic [3:0]  t_be = '0;
  bit          e_if_rv = 0, e_dm_rv = 0;
  logic [31:0] e_if_rd = '0, e_dm_rd = '0;
  int          streak = 0;
  bit          m_if_gnt = 0, m_dm_gnt = 0;

  always @(negedge clk) begin : p_compare
    bit idle, eg_if, eg_dm;
    idle  = !t_valid;
    eg_if = idle && bus.if_req && (!bus.dm_req || streak == LIMIT);
    eg_dm = idle && bus.dm_req && !eg_if;
    if (!rst_n) begin
      check1("rst_mem_req", bus.mem_req, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_if_rvalid", bus.if_rvalid, 1'b0);
      check1("rst_dm_rvalid", bus.dm_rvalid, 1'b0);
      check1("rst_if_gnt", bus.if_gnt, eg_if);
      check1("rst_dm_gnt", bus.dm_gnt, eg_dm);
      check32("rst_mem_addr", bus.mem_addr, 32'h0);
      check32("rst_if_rdata", bus.if_rdata, 32'h0);
      check32("rst_dm_rdata", bus.dm_rdata, 32'h0);
      t_valid = 0; t_drop = 0; e_if_rv = 0; e_dm_rv = 0; streak = 0;
      m_if_gnt = 0; m_dm_gnt = 0;
    end else begin
      check1("mem_req", bus.mem_req, t_valid);
      check1("busy", busy, t_valid);
      if (t_valid) begin
        check32("mem_addr", bus.mem_addr, t_addr);
        check1("mem_we", bus.mem_we, t_we);
        if (!t_is_if) check32("mem_be", 32'(bus.mem_be), 32'(t_be));
        if (!t_is_if && t_we) check32("mem_wdata", bus.mem_wdata, t_wdata);
      end
      check1("if_gnt", bus.if_gnt, eg_if);
      check1("dm_gnt", bus.dm_gnt, eg_dm);
      check1("if_rvalid", bus.if_rvalid, e_if_rv);
      if (e_if_rv) check32("if_rdata", bus.if_rdata, e_if_rd);
      check1("dm_rvalid", bus.dm_rvalid, e_dm_rv);
      if (e_dm_rv) check32("dm_rdata", bus.dm_rdata, e_dm_rd);
      m_if_gnt = eg_if;
      m_dm_gnt = eg_dm;
      e_if_rv = 0;
      e_dm_rv = 0;
      if (t_valid) begin
        if (t_is_if && bus.if_flush) t_drop = 1;
        if (bus.mem_ready) begin
          if (t_is_if) begin
            if (!t_drop) begin
              e_if_rv = 1;
              e_if_rd = bus.mem_rdata;
            end
          end else begin
            e_dm_rv = 1;
            e_dm_rd = t_we ? 32'h0 : bus.mem_rdata;
          end
          t_valid = 0;
          t_drop  = 0;
        end
      end else if (eg_if) begin
        t_valid = 1; t_is_if = 1; t_we = 0; t_addr = bus.if_addr;
        t_drop  = bus.if_flush;
        streak  = 0;
      end else if (eg_dm) begin
        t_valid = 1; t_is_if = 0; t_we = bus.dm_we; t_addr = bus.dm_addr;
        t_wdata = bus.dm_wdata; t_be = bus.dm_be;
        streak  = bus.if_req ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
      end
    end
  end

  initial begin : p_stim
    logic [6:0] seq;
    int         ngrant;
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check1("reset_mem_req", bus.mem_req, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_if_rvalid", bus.if_rvalid, 1'b0);

    // First fetch at minimum latency
    bus.mem_ready = 1; bus.mem_rdata = 32'h00A00093; bus.if_req = 1; bus.if_addr = 32'h0;
    #1 check1("t1_if_gnt", bus.if_gnt, 1'b1);
    tick(); bus.if_req = 0;
    check1("t1_mem_req", bus.mem_req, 1'b1);
    check32("t1_mem_addr", bus.mem_addr, 32'h0);
    tick();
    check1("t1_if_rvalid", bus.if_rvalid, 1'b1);
    check32("t1_if_rdata", bus.if_rdata, 32'h00A00093);

    // Contention: 4 data grants, then fetch, then data again
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100; bus.dm_be = 4'hF;
    seq = '0; ngrant = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (bus.dm_gnt) begin seq = {seq[5:0], 1'b1}; ngrant++; end
      else if (bus.if_gnt) begin seq = {seq[5:0], 1'b0}; ngrant++; end
      tick();
    end
    check32("t2_grant_order", 32'(seq), 32'b1111011);
    check32("t2_grant_count", 32'(ngrant), 32'd7);
    bus.if_req = 0; bus.dm_req = 0;
    tick(); tick();

    // Store with three wait cycles
    bus.mem_ready = 0; bus.mem_rdata = 32'hDEADBEEF;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h1E; bus.dm_be = 4'hF;
    #1 check1("t3_dm_gnt", bus.dm_gnt, 1'b1);
    tick(); bus.dm_req = 0; bus.dm_we = 0;
    for (int k = 0; k < 4; k++) begin
      check1("t3_mem_req", bus.mem_req, 1'b1);
      check1("t3_mem_we", bus.mem_we, 1'b1);
      check32("t3_mem_addr", bus.mem_addr, 32'h40);
      check32("t3_mem_wdata", bus.mem_wdata, 32'h1E);
      check32("t3_mem_be", 32'(bus.mem_be), 32'hF);
      check1("t3_no_early_rvalid", bus.dm_rvalid, 1'b0);
      if (k == 3) bus.mem_ready = 1;
      tick();
    end
    bus.mem_ready = 0;
    check1("t3_dm_rvalid", bus.dm_rvalid, 1'b1);
    check32("t3_dm_rdata", bus.dm_rdata, 32'h0);
    check1("t3_busy", busy, 1'b0);
    tick();
    check1("t3_rvalid_pulse", bus.dm_rvalid, 1'b0);

    // Flush while fetch is in flight
    bus.if_req = 1; bus.if_addr = 32'h34;
    #1 check1("t4_if_gnt", bus.if_gnt, 1'b1);
    tick(); bus.if_req = 0; bus.if_flush = 1;
    tick(); bus.if_flush = 0;
    tick(); bus.mem_ready = 1;
    tick(); bus.mem_ready = 0;
    check1("t4_if_rvalid_dropped", bus.if_rvalid, 1'b0);
    check1("t4_busy", busy, 1'b0);
    bus.mem_rdata = 32'h12345678; bus.if_req = 1; bus.if_addr = 32'h3C; bus.mem_ready = 1;
    #1 check1("t4_next_gnt", bus.if_gnt, 1'b1);
    tick(); bus.if_req = 0;
    check32("t4_next_addr", bus.mem_addr, 32'h3C);
    tick();
    check1("t4_next_rvalid", bus.if_rvalid, 1'b1);
    check32("t4_next_rdata", bus.if_rdata, 32'h12345678);

    // Flush in the grant cycle, then flush coincident with rvalid
    bus.if_req = 1; bus.if_addr = 32'h50; bus.if_flush = 1;
    #1 check1("t5_if_gnt", bus.if_gnt, 1'b1);
    tick(); bus.if_req = 0; bus.if_flush = 0;
    tick();
    check1("t5_rvalid_dropped", bus.if_rvalid, 1'b0);
    bus.if_req = 1; bus.if_addr = 32'h54; bus.mem_rdata = 32'h0BADF00D;
    #1 check1("t5_gnt2", bus.if_gnt, 1'b1);
    tick(); bus.if_req = 0;
    tick(); bus.if_flush = 1;
    #1 check1("t5_rvalid_kept", bus.if_rvalid, 1'b1);
    check32("t5_rdata_kept", bus.if_rdata, 32'h0BADF00D);
    tick(); bus.if_flush = 0;
    check1("t5_idle_flush_busy", busy, 1'b0);

    // Reset during a data access
    bus.mem_ready = 0; bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h80;
    #1 check1("t6_dm_gnt", bus.dm_gnt, 1'b1);
    tick(); bus.dm_req = 0;
    check1("t6_mem_req", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1 check1("t6_mem_req_reset", bus.mem_req, 1'b0);
    check1("t6_busy_reset", busy, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1; bus.mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check1("t6_no_dm_rvalid", bus.dm_rvalid, 1'b0);
    end

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (cyc % 700 == 350) begin
        bus.if_req = 0; bus.dm_req = 0; bus.if_flush = 0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        if (!bus.if_req || m_if_gnt) begin
          bus.if_req  = ($urandom_range(0, 2) != 0);
          bus.if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (!bus.dm_req || m_dm_gnt) begin
          bus.dm_req   = ($urandom_range(0, 2) != 0);
          bus.dm_we    = $urandom_range(0, 1) == 1;
          bus.dm_addr  = $urandom();
          bus.dm_wdata = $urandom();
          bus.dm_be    = 4'($urandom_range(0, 15));
        end
        bus.if_flush  = ($urandom_range(0, 7) == 0);
        bus.mem_ready = ($urandom_range(0, 2) != 0);
        bus.mem_rdata = $urandom();
      end
    end
    bus.if_req = 0; bus.dm_req = 0; bus.if_flush = 0; bus.mem_ready = 1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
